// File: rtl/gaussian_frame_sequencer_if.sv
// Pixel-source read bus plus the video stream sent to, and monitored back from,
// the Gaussian filter. The sequencer connects through the master modport.
interface gaussian_frame_sequencer_if #(
  parameter int ADDR_W = 20
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              out_vsync;
  logic              out_href;
  logic [7:0]        out_gray;
  logic              post_vsync;
  logic              post_href;

  modport master (
    output rd_en, rd_addr, out_vsync, out_href, out_gray,
    input  rd_data, post_vsync, post_href
  );

  modport slave (
    input  rd_en, rd_addr, out_vsync, out_href, out_gray,
    output rd_data, post_vsync, post_href
  );
endinterface

// File: rtl/gaussian_frame_sequencer.sv
// Streams one raster frame from a pixel store into the Gaussian filter and waits for the
// filter output to drain. Define GAUSS_SEQ_FRAME_CNT_EN to add the frame_cnt output.
module gaussian_frame_sequencer #(
  parameter int IMG_H_DISP = 640,
  parameter int IMG_V_DISP = 480,
  parameter int H_BLANK    = 64,
  parameter int VS_PRE     = 16,
  parameter int DRAIN_TMO  = 65535,
  parameter int ADDR_W     = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_err,
`ifdef GAUSS_SEQ_FRAME_CNT_EN
  output logic [15:0] frame_cnt,
`endif
  gaussian_frame_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VS_PRE,
    S_ACTIVE,
    S_HBLANK,
    S_DRAIN
  } state_t;

  localparam int PH_MAX = (IMG_H_DISP > VS_PRE)
                        ? ((IMG_H_DISP > H_BLANK) ? IMG_H_DISP : H_BLANK)
                        : ((VS_PRE > H_BLANK) ? VS_PRE : H_BLANK);
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int LN_W   = $clog2(IMG_V_DISP + 1);
  localparam int DR_W   = $clog2(DRAIN_TMO + 1);

  state_t            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [LN_W-1:0]   line_q, line_d;
  logic [LN_W-1:0]   mon_q, mon_d;
  logic [DR_W-1:0]   drain_q, drain_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic              href_q, href_d;
  logic              vsync_q, vsync_d;
  logic              ph_prev_q, ph_prev_d;
  logic              done;
  logic              timeout;
  logic              last_px;
  logic              href_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      line_q    <= '0;
      mon_q     <= '0;
      drain_q   <= '0;
      addr_q    <= '0;
      err_q     <= 1'b0;
      href_q    <= 1'b0;
      vsync_q   <= 1'b0;
      ph_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      line_q    <= line_d;
      mon_q     <= mon_d;
      drain_q   <= drain_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
      href_q    <= href_d;
      vsync_q   <= vsync_d;
      ph_prev_q <= ph_prev_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    line_d  = line_q;
    drain_d = drain_q;
    addr_d  = addr_q;
    err_d   = err_q;
    done    = 1'b0;
    timeout = 1'b0;
    last_px = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_VS_PRE;
          phase_d = '0;
          line_d  = '0;
          drain_d = '0;
          addr_d  = '0;
          err_d   = 1'b0;
        end
      end

      S_VS_PRE: begin
        if (phase_q == PH_W'(VS_PRE - 1)) begin
          state_d = S_ACTIVE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      S_ACTIVE: begin
        last_px = (phase_q == PH_W'(IMG_H_DISP - 1));
        // The final pixel of the frame leaves rd_addr parked on the last address issued.
        if (!(last_px && (line_q == LN_W'(IMG_V_DISP - 1)))) begin
          addr_d = addr_q + ADDR_W'(1);
        end
        if (last_px) begin
          state_d = S_HBLANK;
          phase_d = '0;
          line_d  = line_q + LN_W'(1);
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      S_HBLANK: begin
        if (phase_q == PH_W'(H_BLANK - 1)) begin
          phase_d = '0;
          state_d = (line_q == LN_W'(IMG_V_DISP)) ? S_DRAIN : S_ACTIVE;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      S_DRAIN: begin
        // Timeout fires once DRAIN_TMO full cycles have elapsed without the filter draining.
        if ((mon_q == LN_W'(IMG_V_DISP)) && !bus.post_vsync) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end else if (drain_q == DR_W'(DRAIN_TMO)) begin
          done    = 1'b1;
          timeout = 1'b1;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          drain_d = drain_q + DR_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Filter-output monitor: counts completed output lines, saturating at the frame height.
  always_comb begin
    ph_prev_d = bus.post_href;
    href_fall = ph_prev_q && !bus.post_href;
    mon_d     = mon_q;
    if (state_q == S_IDLE) begin
      if (start) begin
        mon_d = '0;
      end
    end else if (href_fall && (mon_q != LN_W'(IMG_V_DISP))) begin
      mon_d = mon_q + LN_W'(1);
    end
  end

  always_comb begin
    href_d  = (state_q == S_ACTIVE);
    vsync_d = (state_q == S_VS_PRE) || (state_q == S_ACTIVE) || (state_q == S_HBLANK);
  end

  assign bus.rd_en     = (state_q == S_ACTIVE);
  assign bus.rd_addr   = addr_q;
  assign bus.out_href  = href_q;
  assign bus.out_vsync = vsync_q;
  assign bus.out_gray  = href_q ? bus.rd_data : 8'd0;

  assign busy       = (state_q != S_IDLE);
  assign frame_done = done;
  assign frame_err  = err_q;

`ifdef GAUSS_SEQ_FRAME_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (done && !timeout) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign frame_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_gaussian_frame_sequencer.sv
// Directed bench for gaussian_frame_sequencer on an 8x4 frame; expected timing comes
// from the raster geometry (VS_PRE=2, H_BLANK=3, DRAIN_TMO=50) computed per cycle.
module tb_gaussian_frame_sequencer;

  localparam int H       = 8;
  localparam int V       = 4;
  localparam int HB      = 3;
  localparam int VP      = 2;
  localparam int TMO     = 50;
  localparam int AW      = 20;
  localparam int LINE_T  = H + HB;
  localparam int DRAIN_T = VP + V * LINE_T;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy;
  logic frame_done;
  logic frame_err;
`ifdef GAUSS_SEQ_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  gaussian_frame_sequencer_if #(.ADDR_W(AW)) bus_if ();

  gaussian_frame_sequencer #(
    .IMG_H_DISP(H),
    .IMG_V_DISP(V),
    .H_BLANK   (HB),
    .VS_PRE    (VP),
    .DRAIN_TMO (TMO),
    .ADDR_W    (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .frame_done(frame_done),
    .frame_err (frame_err),
`ifdef GAUSS_SEQ_FRAME_CNT_EN
    .frame_cnt (frame_cnt),
`endif
    .bus       (bus_if)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int filt_mode = 1;       // 0: echo filter (30-cycle delay), 1: silent, 2: manual
  logic [30:0] sr_h = '0;
  logic [30:0] sr_v = '0;
  int frame_id = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; rd_data returns the address read in the previous cycle.
  task automatic tick();
    logic [7:0] a;
    logic       en;
    a  = bus_if.rd_addr[7:0];
    en = bus_if.rd_en;
    @(posedge clk);
    #1;
    bus_if.rd_data = en ? a : 8'hA5;
    if (filt_mode == 0) begin
      sr_h = {sr_h[29:0], bus_if.out_href};
      sr_v = {sr_v[29:0], bus_if.out_vsync};
      bus_if.post_href  = sr_h[30];
      bus_if.post_vsync = sr_v[30];
    end
  endtask

  function automatic bit act_at(input int t);
    int u;
    u = t - VP;
    if (u < 0 || u >= V * LINE_T) return 1'b0;
    return (u % LINE_T) < H;
  endfunction

  function automatic int addr_at(input int t);
    int u;
    u = t - VP;
    return (u / LINE_T) * H + (u % LINE_T);
  endfunction

  // Runs one frame from a start pulse, checking every output each cycle.
  task automatic run_frame(input int mode, input int sb1, input int sb2,
                           input int exp_done_t, input bit exp_err, input int exp_cnt);
    bit a_now;
    bit a_prev;
    frame_id++;
    filt_mode = mode;
    sr_h = '0;
    sr_v = '0;
    bus_if.post_href  = 1'b0;
    bus_if.post_vsync = (mode == 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t <= exp_done_t + 3; t++) begin
      start = (t == sb1) || (t == sb2);
      if (mode == 2) begin
        bus_if.post_href = (t >= DRAIN_T) && (t < DRAIN_T + 18) && (((t - DRAIN_T) % 2) == 0);
        if (t >= 70) bus_if.post_vsync = 1'b0;
      end
      #1;
      a_now  = act_at(t);
      a_prev = act_at(t - 1);
      check($sformatf("f%0d t%0d busy", frame_id, t), 32'(busy), 32'(t <= exp_done_t));
      check($sformatf("f%0d t%0d rd_en", frame_id, t), 32'(bus_if.rd_en), 32'(a_now));
      if (a_now)
        check($sformatf("f%0d t%0d rd_addr", frame_id, t), 32'(bus_if.rd_addr), 32'(addr_at(t)));
      check($sformatf("f%0d t%0d href", frame_id, t), 32'(bus_if.out_href), 32'(a_prev));
      check($sformatf("f%0d t%0d vsync", frame_id, t), 32'(bus_if.out_vsync),
            32'((t >= 1) && (t <= DRAIN_T)));
      check($sformatf("f%0d t%0d gray", frame_id, t), 32'(bus_if.out_gray),
            a_prev ? 32'(addr_at(t - 1)) : 32'd0);
      check($sformatf("f%0d t%0d done", frame_id, t), 32'(frame_done), 32'(t == exp_done_t));
      check($sformatf("f%0d t%0d err", frame_id, t), 32'(frame_err),
            (t <= exp_done_t) ? 32'd0 : 32'(exp_err));
      tick();
    end
    start = 1'b0;
    check($sformatf("f%0d last_addr", frame_id), 32'(bus_if.rd_addr), 32'(H * V - 1));
`ifdef GAUSS_SEQ_FRAME_CNT_EN
    check($sformatf("f%0d frame_cnt", frame_id), 32'(frame_cnt), 32'(exp_cnt));
`endif
    $display("frame %0d: mode=%0d done_t=%0d err=%0b cnt_exp=%0d", frame_id, mode,
             exp_done_t, frame_err, exp_cnt);
  endtask

  initial begin
    int saw_done;
    bus_if.rd_data    = 8'h00;
    bus_if.post_href  = 1'b0;
    bus_if.post_vsync = 1'b0;
    rst_n = 1'b0;
    filt_mode = 1;
    tick();
    tick();
    check("rst busy", 32'(busy), 32'd0);
    check("rst rd_en", 32'(bus_if.rd_en), 32'd0);
    check("rst rd_addr", 32'(bus_if.rd_addr), 32'd0);
    check("rst vsync", 32'(bus_if.out_vsync), 32'd0);
    check("rst href", 32'(bus_if.out_href), 32'd0);
    check("rst done", 32'(frame_done), 32'd0);
    check("rst err", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();

    // Echoed filter: done after 4th post_href fall once post_vsync drops (t=77).
    run_frame(0, -1, -1, 77, 1'b0, 1);
    // Silent filter: drain timeout 50 cycles after DRAIN entry (t=46+50).
    run_frame(1, -1, -1, 96, 1'b1, 1);
    for (int i = 0; i < 3; i++) tick();
    check("err sticky", 32'(frame_err), 32'd1);
    // Start pulses during ACTIVE and coincident with frame_done are ignored.
    run_frame(0, 5, 77, 77, 1'b0, 2);
    // Nine post_href falls with post_vsync high: monitor must saturate, not wrap.
    run_frame(2, -1, -1, 70, 1'b0, 3);

    // Reset in the middle of line 2.
    filt_mode = 1;
    bus_if.post_href  = 1'b0;
    bus_if.post_vsync = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 30; t++) tick();
    check("pre-rst href", 32'(bus_if.out_href), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst rd_en", 32'(bus_if.rd_en), 32'd0);
    check("midrst rd_addr", 32'(bus_if.rd_addr), 32'd0);
    check("midrst vsync", 32'(bus_if.out_vsync), 32'd0);
    check("midrst href", 32'(bus_if.out_href), 32'd0);
    check("midrst gray", 32'(bus_if.out_gray), 32'd0);
    check("midrst done", 32'(frame_done), 32'd0);
`ifdef GAUSS_SEQ_FRAME_CNT_EN
    check("midrst frame_cnt", 32'(frame_cnt), 32'd0);
`endif
    tick();
    tick();
    rst_n = 1'b1;
    saw_done = 0;
    for (int t = 0; t < 100; t++) begin
      tick();
      if (frame_done || busy) saw_done++;
    end
    check("post-rst quiet", 32'(saw_done), 32'd0);
    $display("reset mid-frame: outputs cleared, quiet cycles checked");

    run_frame(0, -1, -1, 77, 1'b0, 1);
    run_frame(0, -1, -1, 77, 1'b0, 2);
    run_frame(1, -1, -1, 96, 1'b1, 2);
    run_frame(0, -1, -1, 77, 1'b0, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/gaussian_frame_sequencer.md
GAUSSIAN_FRAME_SEQUENCER -- requirements
Module: gaussian_frame_sequencer

Interface
REQ-001 SHALL have parameter IMG_H_DISP, default 640, active pixels per line.
REQ-002 SHALL have parameter IMG_V_DISP, default 480, active lines per frame.
REQ-003 SHALL have parameter H_BLANK, default 64, href-low cycles between lines (minimum 1).
REQ-004 SHALL have parameter VS_PRE, default 16, vsync-high cycles before first line (minimum 1).
REQ-005 SHALL have parameter DRAIN_TMO, default 65535, maximum drain-wait cycles.
REQ-006 SHALL have parameter ADDR_W, default 20, read address width.
REQ-007 SHALL have ports: clk in 1, clock; rst_n in 1, reset (asynchronous, active-low); start in 1, frame request pulse; busy out 1, frame in progress.
REQ-008 SHALL have ports: rd_en out 1, pixel read strobe; rd_addr out ADDR_W, raster pixel address; rd_data in 8, source pixel (valid exactly 1 cycle after rd_en).
REQ-009 SHALL have ports: out_vsync out 1, out_href out 1, out_gray out 8 (filter input stream); post_vsync in 1, post_href in 1 (filter output monitor).
REQ-010 SHALL have ports: frame_done out 1, one-cycle completion pulse; frame_err out 1, sticky drain-timeout flag.

Function
REQ-011 SHALL implement FSM states IDLE, VS_PRE, ACTIVE, HBLANK, DRAIN.
REQ-012 IDLE: start=1 -> VS_PRE, rd_addr<=0, line/pixel/drain counters<=0, frame_err<=0; start in any other state SHALL be ignored.
REQ-013 VS_PRE: stay exactly VS_PRE cycles, then -> ACTIVE.
REQ-014 ACTIVE: rd_en=1 every cycle, rd_addr increments by 1 per cycle; after IMG_H_DISP cycles -> HBLANK.
REQ-015 HBLANK: stay H_BLANK cycles; if IMG_V_DISP lines issued -> DRAIN, else -> ACTIVE.
REQ-016 out_href SHALL equal (state==ACTIVE) delayed 1 cycle; out_gray SHALL equal rd_data when out_href=1, else 0.
REQ-017 out_vsync SHALL equal (state in VS_PRE, ACTIVE, HBLANK) delayed 1 cycle.
REQ-018 busy SHALL be 1 in every state except IDLE.
REQ-019 A monitor SHALL count post_href falling edges from VS_PRE entry onward, counter width ceil(log2(IMG_V_DISP+1)).
REQ-020 DRAIN: when monitor count == IMG_V_DISP and post_vsync==0 -> IDLE with frame_done=1 for one cycle.
REQ-021 DRAIN: after DRAIN_TMO cycles without REQ-020 condition -> IDLE, frame_done=1 one cycle, frame_err<=1.
REQ-022 Last address issued per frame SHALL be IMG_H_DISP*IMG_V_DISP-1; rd_addr SHALL hold its value in non-ACTIVE states.
REQ-023 Extra post_href edges beyond IMG_V_DISP SHALL saturate the monitor count, not wrap.
REQ-024 start coincident with frame_done SHALL be ignored (FSM still in DRAIN that cycle).

Reset
REQ-025 rst_n=0 SHALL asynchronously force state IDLE and all outputs/counters to 0.
REQ-026 Reset mid-frame SHALL abort the frame with no frame_done pulse; out_vsync/out_href SHALL be 0 from the reset edge.

Configuration
REQ-027 With macro GAUSS_SEQ_FRAME_CNT_EN defined, SHALL add output frame_cnt [15:0], incremented (wrapping) on each frame_done without frame_err, reset 0.
REQ-028 Without GAUSS_SEQ_FRAME_CNT_EN, port frame_cnt and its logic SHALL not exist; all other behaviour identical.

Verification (IMG_H_DISP=8, IMG_V_DISP=4, H_BLANK=3, VS_PRE=2, DRAIN_TMO=50)
REQ-029 start pulse, rd_data=rd_addr[7:0] -> out_vsync rises 1 cycle after VS_PRE entry; 4 href bursts of 8 cycles, 3-cycle gaps; out_gray 0..31; rd_addr ends at 31.
REQ-030 Model filter echoing out_href/out_vsync after 30 cycles -> frame_done single pulse after 4th post_href fall with post_vsync low; frame_err=0.
REQ-031 post_href held 0 -> frame_done exactly 50 cycles after DRAIN entry, frame_err=1 until next start.
REQ-032 start pulsed during ACTIVE and coincident with frame_done -> no restart, address sequence unchanged, busy falls once.
REQ-033 rst_n low during line 2 -> all outputs 0 immediately, no frame_done; next start produces full 32-pixel frame from address 0.
REQ-034 With GAUSS_SEQ_FRAME_CNT_EN: 3 good frames plus 1 timed-out frame -> frame_cnt=3.
